// File: rtl/apb_master_arbiter_if.sv
// Requester and APB bus signals of the two-requester APB master.
// master: the arbiter's view; slave: the view of the requesters and APB slaves around it.
interface apb_master_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 8
);
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_accept;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   PADDR;
  logic            PWRITE;
  logic            PSEL1;
  logic            PSEL2;
  logic            PENABLE;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_accept, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWRITE, PSEL1, PSEL2, PENABLE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_accept, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWRITE, PSEL1, PSEL2, PENABLE, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master driving two slaves selected by the top address bit.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 8
`ifdef APB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_master_arbiter_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_paddr, w_paddr_nx;
  logic          r_pwrite, w_pwrite_nx;
  logic [DW-1:0] r_pwdata, w_pwdata_nx;
  logic          r_psel1, w_psel1_nx;
  logic          r_psel2, w_psel2_nx;
  logic          r_penable, w_penable_nx;
  logic [1:0]    r_rsp_valid, w_rsp_valid_nx;
  logic [DW-1:0] r_rsp_rdata, w_rsp_rdata_nx;
  logic          r_rsp_err, w_rsp_err_nx;
  logic          r_last_grant, w_last_grant_nx;
  logic          r_owner, w_owner_nx;
  logic [1:0]    w_accept;
  logic          w_win;
  logic [AW-1:0] w_addr;
  logic          w_write;
  logic [DW-1:0] w_wdata;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = 8;
  logic [CW-1:0] r_cnt, w_cnt_nx;
`endif

  // Round-robin winner: a lone requester wins, a tie goes away from the last grant
  always_comb begin
    w_win   = (bus.req_valid == 2'b11) ? ~r_last_grant : bus.req_valid[1];
    w_addr  = w_win ? bus.req_addr[AW +: AW]  : bus.req_addr[0 +: AW];
    w_write = w_win ? bus.req_write[1]        : bus.req_write[0];
    w_wdata = w_win ? bus.req_wdata[DW +: DW] : bus.req_wdata[0 +: DW];
  end

  always_comb begin
    w_state_nx      = r_state;
    w_paddr_nx      = r_paddr;
    w_pwrite_nx     = r_pwrite;
    w_pwdata_nx     = r_pwdata;
    w_psel1_nx      = r_psel1;
    w_psel2_nx      = r_psel2;
    w_penable_nx    = r_penable;
    w_rsp_valid_nx  = 2'b00;
    w_rsp_rdata_nx  = '0;
    w_rsp_err_nx    = 1'b0;
    w_last_grant_nx = r_last_grant;
    w_owner_nx      = r_owner;
    w_accept        = 2'b00;
`ifdef APB_TIMEOUT_EN
    w_cnt_nx        = r_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          w_accept        = w_win ? 2'b10 : 2'b01;
          w_paddr_nx      = w_addr;
          w_pwrite_nx     = w_write;
          w_pwdata_nx     = w_write ? w_wdata : '0;
          w_last_grant_nx = w_win;
          w_owner_nx      = w_win;
          w_psel1_nx      = ~w_addr[AW-1];
          w_psel2_nx      = w_addr[AW-1];
          w_penable_nx    = 1'b0;
          w_state_nx      = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nx = 1'b1;
        w_state_nx   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        w_cnt_nx     = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          w_psel1_nx     = 1'b0;
          w_psel2_nx     = 1'b0;
          w_penable_nx   = 1'b0;
          w_state_nx     = S_IDLE;
          w_rsp_valid_nx = r_owner ? 2'b10 : 2'b01;
          w_rsp_rdata_nx = r_pwrite ? '0 : bus.PRDATA;
          w_rsp_err_nx   = bus.PSLVERR;
        end
`ifdef APB_TIMEOUT_EN
        // Abandon a slave that never answers and report it as an error
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_psel1_nx     = 1'b0;
          w_psel2_nx     = 1'b0;
          w_penable_nx   = 1'b0;
          w_state_nx     = S_IDLE;
          w_rsp_valid_nx = r_owner ? 2'b10 : 2'b01;
          w_rsp_err_nx   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
`endif
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state      <= S_IDLE;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_psel1      <= 1'b0;
      r_psel2      <= 1'b0;
      r_penable    <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_paddr      <= w_paddr_nx;
      r_pwrite     <= w_pwrite_nx;
      r_pwdata     <= w_pwdata_nx;
      r_psel1      <= w_psel1_nx;
      r_psel2      <= w_psel2_nx;
      r_penable    <= w_penable_nx;
      r_rsp_valid  <= w_rsp_valid_nx;
      r_rsp_rdata  <= w_rsp_rdata_nx;
      r_rsp_err    <= w_rsp_err_nx;
      r_last_grant <= w_last_grant_nx;
      r_owner      <= w_owner_nx;
`ifdef APB_TIMEOUT_EN
      r_cnt        <= w_cnt_nx;
`endif
    end
  end

  assign bus.req_accept = w_accept;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.PADDR      = r_paddr;
  assign bus.PWRITE     = r_pwrite;
  assign bus.PWDATA     = r_pwdata;
  assign bus.PSEL1      = r_psel1;
  assign bus.PSEL2      = r_psel2;
  assign bus.PENABLE    = r_penable;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter against a transaction-level model of
// round-robin arbitration, APB phase sequencing and response return.
module tb_apb_master_arbiter;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_arbiter_if #(.AW(AW), .DW(DW)) bus();

  apb_master_arbiter #(
    .AW(AW), .DW(DW)
`ifdef APB_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) u_dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: last granted requester and each requester's pending request
  logic          m_last;
  logic [1:0]    m_pend;
  logic [AW-1:0] m_addr [2];
  logic          m_wr   [2];
  logic [DW-1:0] m_wd   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    bus.req_valid = m_pend;
    bus.req_write = {m_wr[1], m_wr[0]};
    bus.req_addr  = {m_addr[1], m_addr[0]};
    bus.req_wdata = {m_wd[1], m_wd[0]};
  endtask

  task automatic new_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_pend[k] = 1'b1;
    m_wr[k]   = wr;
    m_addr[k] = a;
    m_wd[k]   = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_paddr"},  32'(bus.PADDR), 0);
    chk({tag, "_pwrite"}, 32'(bus.PWRITE), 0);
    chk({tag, "_pwdata"}, 32'(bus.PWDATA), 0);
    chk({tag, "_psel"},   32'({bus.PSEL2, bus.PSEL1, bus.PENABLE}), 0);
    chk({tag, "_rsp"},    32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 0);
  endtask

  // One cycle in IDLE with nothing requested
  task automatic idle_cycle();
    m_pend = 2'b00;
    drive_req();
    #1;
    chk("idle_accept", 32'(bus.req_accept), 0);
    step();
    chk("idle_psel", 32'({bus.PSEL2, bus.PSEL1, bus.PENABLE}), 0);
  endtask

  // Full transfer starting in an IDLE cycle; ends in the response cycle
  task automatic xfer(input int waits, input logic [DW-1:0] rd, input logic err, output int w);
    logic [1:0]    oh;
    logic [1:0]    sel;
    logic [AW-1:0] a;
    logic          wr;
    logic [DW-1:0] wd;
    bit            to;
    drive_req();
    #1;
    w  = (m_pend == 2'b11) ? (m_last ? 0 : 1) : (m_pend[1] ? 1 : 0);
    oh = (w == 1) ? 2'b10 : 2'b01;
    a  = m_addr[w];
    wr = m_wr[w];
    wd = wr ? m_wd[w] : '0;
    sel = a[AW-1] ? 2'b10 : 2'b01;
    chk("accept", 32'(bus.req_accept), 32'(oh));
    step();
    m_last    = w[0];
    chk("setup_accept", 32'(bus.req_accept), 0);
    m_pend[w] = 1'b0;
    drive_req();
    chk("setup_psel",    32'({bus.PSEL2, bus.PSEL1}), 32'(sel));
    chk("setup_penable", 32'(bus.PENABLE), 0);
    chk("setup_paddr",   32'(bus.PADDR), 32'(a));
    chk("setup_pwrite",  32'(bus.PWRITE), 32'(wr));
    chk("setup_pwdata",  32'(bus.PWDATA), 32'(wd));
    chk("setup_rsp",     32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 0);
    step();
    to = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      chk("access_penable", 32'(bus.PENABLE), 1);
      chk("access_hold", 32'({bus.PSEL2, bus.PSEL1, bus.PADDR, bus.PWDATA}), 32'({sel, a, wd}));
      chk("access_rsp", 32'(bus.rsp_valid), 0);
      bus.PREADY  = (k == waits);
      bus.PRDATA  = rd;
      bus.PSLVERR = err;
      step();
`ifdef APB_TIMEOUT_EN
      if (k == int'(TO) - 1 && k != waits) begin
        to = 1'b1;
        break;
      end
`endif
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = DW'($urandom);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    chk("rsp_rdata", 32'(bus.rsp_rdata), (to || wr) ? 0 : 32'(rd));
    chk("rsp_err",   32'(bus.rsp_err), to ? 1 : 32'(err));
    chk("rsp_bus",   32'({bus.PSEL2, bus.PSEL1, bus.PENABLE}), 0);
    chk("rsp_hold",  32'({bus.PADDR, bus.PWRITE}), 32'({a, wr}));
  endtask

  initial begin
    int w;
    int rr_exp [4];
    rr_exp = '{0, 1, 0, 1};
    rst = 1'b1;
    m_last = 1'b1;
    m_pend = 2'b00;
    for (int k = 0; k < 2; k++) new_req(k, 1'b0, '0, '0);
    m_pend = 2'b00;
    drive_req();
    bus.PRDATA = '0;
    bus.PREADY = 1'b0;
    bus.PSLVERR = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    chk("reset_accept", 32'(bus.req_accept), 0);
    rst = 1'b0;

    // Directed: write with no waits, read with two waits, slave error
    new_req(0, 1'b1, 9'h012, 8'hA5);
    xfer(0, 8'h00, 1'b0, w);
    new_req(1, 1'b0, 9'h1F0, 8'h77);
    xfer(2, 8'h3C, 1'b0, w);
    new_req(0, 1'b0, 9'h044, 8'h00);
    xfer(0, 8'h5A, 1'b1, w);

    // A silent slave: times out when enabled, otherwise waits it out
    new_req(0, 1'b0, 9'h0AA, 8'h00);
    xfer(20, 8'h99, 1'b0, w);
    idle_cycle();

    // Reset during ACCESS aborts without a response
    new_req(0, 1'b0, 9'h155, 8'h00);
    drive_req();
    step();
    m_pend = 2'b00;
    drive_req();
    step();
    step();
    rst = 1'b1;
    step();
    chk_all_zero("abort");
    rst = 1'b0;
    m_last = 1'b1;
    step();
    chk("abort_no_rsp", 32'({bus.rsp_valid, bus.PSEL2, bus.PSEL1, bus.PENABLE}), 0);

    // Both requesters continuously valid: strict alternation from requester 0
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 2; k++)
        if (!m_pend[k]) new_req(k, 1'($urandom), AW'($urandom), DW'($urandom));
      xfer(0, DW'($urandom), 1'b0, w);
      chk("rr_order", 32'(w), 32'(rr_exp[t]));
    end

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      for (int k = 0; k < 2; k++)
        if (!m_pend[k] && ($urandom_range(0, 2) != 0))
          new_req(k, 1'($urandom), AW'($urandom), DW'($urandom));
      if (m_pend == 2'b00) begin
        idle_cycle();
      end else begin
        xfer(int'($urandom_range(0, 3)), DW'($urandom), ($urandom_range(0, 7) == 0), w);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master for the two-slave APB subsystem (AW=9, DW=8).
- Accepts transfer requests from two local requesters and arbitrates them round-robin.
- Sequences the granted transfer through the APB IDLE/SETUP/ACCESS phases and decodes the slave select (PSEL1/PSEL2) from the top address bit.
- Returns read data and error status to the requester that issued the transfer.

Parameters:
- AW, 9: APB address width.
- DW, 8: APB data width.
- TIMEOUT, 16: max ACCESS cycles without PREADY. Used only with APB_TIMEOUT_EN. Legal range 2..255.

Ports:
- PCLK  input  1  bus clock; all logic on rising edge.
- PRESET  input  1  synchronous, active-high reset.
- req_valid  input  2  bit k: requester k has a pending transfer; held until accepted.
- req_write  input  2  bit k: 1 = write, 0 = read.
- req_addr  input  2*AW  requester k address at [k*AW +: AW].
- req_wdata  input  2*DW  requester k write data at [k*DW +: DW].
- req_accept  output  2  one-cycle pulse, bit k: request k latched this cycle.
- rsp_valid  output  2  one-cycle pulse, bit k: requester k transfer complete.
- rsp_rdata  output  DW  read data; valid with rsp_valid.
- rsp_err  output  1  slave error or timeout; valid with rsp_valid.
- PADDR  output  AW  APB address.
- PWRITE  output  1  APB write enable.
- PSEL1  output  1  slave 1 select.
- PSEL2  output  1  slave 2 select.
- PENABLE  output  1  APB enable.
- PWDATA  output  DW  APB write data.
- PRDATA  input  DW  APB read data.
- PREADY  input  1  slave ready.
- PSLVERR  input  1  slave error.

Behaviour:
- Reset (PRESET=1 at an edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The round-robin pointer last_grant resets to 1, so requester 0 wins the first tie.
  - Reset mid-transfer aborts at that same edge. PSEL/PENABLE drop and no rsp_valid is issued for the aborted transfer.
- FSM states are IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - If any req_valid is high, choose a winner w.
  - A single valid requester wins outright.
  - If both are valid, w = ~last_grant.
  - req_accept[w] is asserted combinationally in this cycle; it is never asserted outside IDLE.
  - At the edge:
    - Latch PADDR=req_addr[w] and PWRITE=req_write[w].
    - PWDATA=req_wdata[w] for writes, 0 for reads.
    - Set last_grant=w and record owner id.
    - Set PSEL1=~req_addr[w][AW-1] and PSEL2=req_addr[w][AW-1]. Exactly one PSEL is high.
    - PENABLE=0; go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE=1 and go to ACCESS.
- ACCESS:
  - PADDR, PWRITE, PWDATA and PSELx are held stable.
  - While PREADY=0, stay in ACCESS (wait states).
  - When PREADY=1 at an edge:
    - PSELx=0 and PENABLE=0; go to IDLE.
    - rsp_valid[id]=1 for the next cycle.
    - rsp_rdata=PRDATA for reads, 0 for writes.
    - rsp_err=PSLVERR.
- Outputs after a transfer:
  - rsp_valid, rsp_rdata and rsp_err return to 0 the cycle after the pulse.
  - PADDR, PWRITE and PWDATA hold their last values in IDLE.
- Timing:
  - Minimum 3 cycles per transfer (IDLE→SETUP→ACCESS), plus wait states.
  - No back-to-back SETUP; IDLE always intervenes.
  - rsp_valid for transfer n coincides with the IDLE cycle that may accept transfer n+1.
- Requester rules:
  - A requester must not change its req_* inputs while valid and not yet accepted.
  - The block ignores req_valid outside IDLE.
  - Same requester valid again immediately after its transfer: it is still arbitrated against the other per round-robin.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - If the count reaches TIMEOUT-1 with PREADY=0, the transfer terminates at that edge. PSELx/PENABLE go to 0 and the FSM goes to IDLE.
  - The following cycle gives rsp_valid[id]=1, rsp_err=1, rsp_rdata=0.
  - PREADY=1 on the terminating cycle takes priority: normal completion.
- When not defined: no counter is present, and ACCESS waits indefinitely for PREADY.

Test Plan:
- Write, no wait states:
  - Stimulus: req0 write, addr 0x012, data 0xA5; PREADY=1.
  - Response:
    - Cycle 0: req_accept=01.
    - Cycle 1: PSEL1=1, PSEL2=0, PENABLE=0, PADDR=0x012, PWDATA=0xA5.
    - Cycle 2: PENABLE=1.
    - Cycle 3: rsp_valid=01, rsp_err=0.
- Read with wait states:
  - Stimulus: req1 read, addr 0x1F0; PREADY low for 2 ACCESS cycles, then high with PRDATA=0x3C.
  - Response: PSEL2=1, PSEL1=0; PENABLE high 3 cycles; then rsp_valid=10, rsp_rdata=0x3C.
- Arbitration:
  - Stimulus: both requesters continuously valid for 4 transfers after reset.
  - Response: grants in order 0,1,0,1, with exactly one req_accept bit per transfer.
- Slave error:
  - Stimulus: req0 read with PSLVERR=1 and PREADY=1 in ACCESS.
  - Response: rsp_valid=01, rsp_err=1.
- Reset mid-transfer:
  - Stimulus: PRESET=1 during ACCESS.
  - Response: at the reset edge PSEL1=PSEL2=PENABLE=0 and all outputs are 0. No rsp_valid follows. A tie after release grants requester 0.
- Timeout (APB_TIMEOUT_EN, TIMEOUT=4):
  - Stimulus: PREADY held 0.
  - Response: PENABLE high 4 cycles, then rsp_valid=01, rsp_err=1, rsp_rdata=0, FSM back in IDLE.
  - Without the macro, PENABLE stays high.
